// File: rtl/sdram_resp.sv
// sdram_resp: single-chip x16 SDRAM device model backed by on-chip RAM, decoding the controller command bus.
// Optional feature macro: SDRAM_RESP_CHECK_EN (tRCD/tRP timers plus err/err_code reporting).
module sdram_resp #(
    parameter int ROW_W = 4,
    parameter int COL_W = 9,
    parameter int TRCD  = 2,
    parameter int TRP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_ok,
    output logic        err,
    output logic [2:0]  err_code
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;
    localparam logic [COL_W-1:0] COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_ACT   = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_BSTOP = 3'd4,
        CMD_PRE   = 3'd5,
        CMD_AREF  = 3'd6,
        CMD_LMR   = 3'd7
    } cmd_t;

    function automatic logic [3:0] bl_beats(input logic [2:0] code);
        case (code)
            3'b000:  bl_beats = 4'd1;
            3'b001:  bl_beats = 4'd2;
            3'b010:  bl_beats = 4'd4;
            3'b011:  bl_beats = 4'd8;
            default: bl_beats = 4'd1;
        endcase
    endfunction

    cmd_t             cmd_s;
    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [3:0]       rem_q, rem_d;
    logic             page_q, page_d;
    logic [1:0]       bank_q, bank_d;
    logic [3:0]       open_q, open_d;
    logic [ROW_W-1:0] row_q [4];
    logic [ROW_W-1:0] row_d [4];
    logic             cl3_q, cl3_d;
    logic [2:0]       bl_q, bl_d;
    logic             wsingle_q, wsingle_d;
    logic             mode_ok_q, mode_ok_d;

    logic             beat_s, beat_wr_s, flush_s, is_rw_s, stop_s, lmr_cl_ok_s, page_s;
    logic [1:0]       beat_bank_s;
    logic [COL_W-1:0] beat_col_s;
    logic [3:0]       len_s;
    logic [AW-1:0]    mem_addr_s;

    logic [7:0]       mem_lo [DEPTH];
    logic [7:0]       mem_hi [DEPTH];
    logic [7:0]       rd_lo_q, rd_hi_q;
    logic [15:0]      rd_data_s;
    logic             rd_v_q, rd_v_d;
    logic             p1_v_q, p1_v_d;
    logic [15:0]      p1_data_q, p1_data_d;
    logic             dq_oe_q, dq_oe_d;
    logic [15:0]      dq_out_q, dq_out_d;

    logic             unused_s;
    assign unused_s = ^sdram_addr;

    // Command decode; deselect and clock-suspend both collapse to NOP.
    always_comb begin
        cmd_s = CMD_NOP;
        if (sdram_cke && !sdram_cs_n) begin
            case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
                3'b011:  cmd_s = CMD_ACT;
                3'b101:  cmd_s = CMD_READ;
                3'b100:  cmd_s = CMD_WRITE;
                3'b110:  cmd_s = CMD_BSTOP;
                3'b010:  cmd_s = CMD_PRE;
                3'b001:  cmd_s = CMD_AREF;
                3'b000:  cmd_s = CMD_LMR;
                default: cmd_s = CMD_NOP;
            endcase
        end else begin
            cmd_s = CMD_NOP;
        end
    end

    assign lmr_cl_ok_s = (sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3);
    assign is_rw_s     = ((cmd_s == CMD_READ) || (cmd_s == CMD_WRITE)) && mode_ok_q && open_q[sdram_ba];
    assign stop_s      = (cmd_s == CMD_BSTOP) ||
                         ((cmd_s == CMD_PRE) && (sdram_addr[10] || (sdram_ba == bank_q)));

    // Bank/mode bookkeeping and burst sequencing; one beat per enabled cycle.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rem_d       = rem_q;
        page_d      = page_q;
        bank_d      = bank_q;
        open_d      = open_q;
        row_d       = row_q;
        cl3_d       = cl3_q;
        bl_d        = bl_q;
        wsingle_d   = wsingle_q;
        mode_ok_d   = mode_ok_q;
        beat_s      = 1'b0;
        beat_wr_s   = 1'b0;
        beat_bank_s = bank_q;
        beat_col_s  = col_q;
        flush_s     = 1'b0;
        len_s       = 4'd1;
        page_s      = 1'b0;

        case (cmd_s)
            CMD_ACT: begin
                if (!open_q[sdram_ba]) begin
                    open_d[sdram_ba] = 1'b1;
                    row_d[sdram_ba]  = sdram_addr[ROW_W-1:0];
                end else begin
                    open_d[sdram_ba] = 1'b1;
                end
            end
            CMD_PRE: begin
                if (sdram_addr[10]) begin
                    open_d = 4'b0000;
                end else begin
                    open_d[sdram_ba] = 1'b0;
                end
            end
            CMD_LMR: begin
                if (lmr_cl_ok_s) begin
                    cl3_d     = (sdram_addr[6:4] == 3'd3);
                    bl_d      = sdram_addr[2:0];
                    wsingle_d = sdram_addr[9];
                    mode_ok_d = 1'b1;
                end else begin
                    mode_ok_d = mode_ok_q;
                end
            end
            default: begin
                open_d = open_q;
            end
        endcase

        if (is_rw_s) begin
            // A new READ/WRITE replaces any running burst in the same cycle.
            if ((cmd_s == CMD_WRITE) && wsingle_q) begin
                page_s = 1'b0;
                len_s  = 4'd1;
            end else begin
                page_s = (bl_q == 3'b111);
                len_s  = bl_beats(bl_q);
            end
            beat_s      = 1'b1;
            beat_wr_s   = (cmd_s == CMD_WRITE);
            flush_s     = (cmd_s == CMD_WRITE);
            beat_bank_s = sdram_ba;
            beat_col_s  = sdram_addr[COL_W-1:0];
            bank_d      = sdram_ba;
            col_d       = sdram_addr[COL_W-1:0] + COL_ONE;
            page_d      = page_s;
            rem_d       = len_s - 4'd1;
            if (page_s || (len_s != 4'd1)) begin
                state_d = (cmd_s == CMD_WRITE) ? ST_WR : ST_RD;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q != ST_IDLE) && stop_s) begin
            state_d = ST_IDLE;
        end else if ((state_q != ST_IDLE) && sdram_cke) begin
            beat_s    = 1'b1;
            beat_wr_s = (state_q == ST_WR);
            col_d     = col_q + COL_ONE;
            if (page_q) begin
                rem_d = rem_q;
            end else if (rem_q <= 4'd1) begin
                rem_d   = 4'd0;
                state_d = ST_IDLE;
            end else begin
                rem_d = rem_q - 4'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    assign mem_addr_s = {beat_bank_s, row_q[beat_bank_s], beat_col_s};
    assign rd_data_s  = {rd_hi_q, rd_lo_q};

    // Byte-lane storage; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && beat_s && beat_wr_s && !sdram_dqm[0]) begin
            mem_lo[mem_addr_s] <= dq_in[7:0];
        end
        if (rst_n && beat_s && beat_wr_s && !sdram_dqm[1]) begin
            mem_hi[mem_addr_s] <= dq_in[15:8];
        end
        rd_lo_q <= mem_lo[mem_addr_s];
        rd_hi_q <= mem_hi[mem_addr_s];
    end

    // CAS-latency pipeline: RAM read gives CL2, one extra stage gives CL3; a WRITE flushes it.
    always_comb begin
        rd_v_d    = beat_s && !beat_wr_s;
        p1_v_d    = rd_v_q && !flush_s;
        p1_data_d = rd_data_s;
        if (cl3_q) begin
            dq_oe_d  = p1_v_q && !flush_s;
            dq_out_d = (p1_v_q && !flush_s) ? p1_data_q : 16'h0000;
        end else begin
            dq_oe_d  = rd_v_q && !flush_s;
            dq_out_d = (rd_v_q && !flush_s) ? rd_data_s : 16'h0000;
        end
    end

    // Main state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= {COL_W{1'b0}};
            rem_q     <= 4'd0;
            page_q    <= 1'b0;
            bank_q    <= 2'd0;
            open_q    <= 4'b0000;
            for (int b = 0; b < 4; b++) row_q[b] <= {ROW_W{1'b0}};
            cl3_q     <= 1'b1;
            bl_q      <= 3'b111;
            wsingle_q <= 1'b0;
            mode_ok_q <= 1'b0;
            rd_v_q    <= 1'b0;
            p1_v_q    <= 1'b0;
            p1_data_q <= 16'h0000;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            rem_q     <= rem_d;
            page_q    <= page_d;
            bank_q    <= bank_d;
            open_q    <= open_d;
            row_q     <= row_d;
            cl3_q     <= cl3_d;
            bl_q      <= bl_d;
            wsingle_q <= wsingle_d;
            mode_ok_q <= mode_ok_d;
            rd_v_q    <= rd_v_d;
            p1_v_q    <= p1_v_d;
            p1_data_q <= p1_data_d;
            dq_oe_q   <= dq_oe_d;
            dq_out_q  <= dq_out_d;
        end
    end

    assign dq_out  = dq_out_q;
    assign dq_oe   = dq_oe_q;
    assign mode_ok = mode_ok_q;

`ifdef SDRAM_RESP_CHECK_EN
    localparam logic [3:0] TRCD_LD = (TRCD > 1) ? 4'(TRCD - 1) : 4'd0;
    localparam logic [3:0] TRP_LD  = (TRP > 1) ? 4'(TRP - 1) : 4'd0;

    logic [3:0] trcd_q [4];
    logic [3:0] trcd_d [4];
    logic [3:0] trp_q [4];
    logic [3:0] trp_d [4];
    logic [2:0] cause_s;
    logic       err_q, err_d;
    logic [2:0] err_code_q, err_code_d;

    // Per-bank countdowns loaded by ACT (tRCD) and by PRE of an open bank (tRP).
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            if ((cmd_s == CMD_ACT) && !open_q[b] && (sdram_ba == 2'(b))) begin
                trcd_d[b] = TRCD_LD;
            end else if (trcd_q[b] != 4'd0) begin
                trcd_d[b] = trcd_q[b] - 4'd1;
            end else begin
                trcd_d[b] = 4'd0;
            end
            if ((cmd_s == CMD_PRE) && open_q[b] && (sdram_addr[10] || (sdram_ba == 2'(b)))) begin
                trp_d[b] = TRP_LD;
            end else if (trp_q[b] != 4'd0) begin
                trp_d[b] = trp_q[b] - 4'd1;
            end else begin
                trp_d[b] = 4'd0;
            end
        end
    end

    // Classify the current command; only the first cause is latched until reset.
    always_comb begin
        cause_s = 3'd0;
        case (cmd_s)
            CMD_ACT:   cause_s = open_q[sdram_ba] ? 3'd1 : ((trp_q[sdram_ba] != 4'd0) ? 3'd4 : 3'd0);
            CMD_READ,
            CMD_WRITE: begin
                if (!mode_ok_q) begin
                    cause_s = 3'd0;
                end else if (!open_q[sdram_ba]) begin
                    cause_s = 3'd2;
                end else if (trcd_q[sdram_ba] != 4'd0) begin
                    cause_s = 3'd3;
                end else begin
                    cause_s = 3'd0;
                end
            end
            CMD_AREF:  cause_s = (|open_q) ? 3'd5 : 3'd0;
            CMD_LMR:   cause_s = lmr_cl_ok_s ? 3'd0 : 3'd6;
            default:   cause_s = 3'd0;
        endcase
        if (!err_q && (cause_s != 3'd0)) begin
            err_d      = 1'b1;
            err_code_d = cause_s;
        end else begin
            err_d      = err_q;
            err_code_d = err_code_q;
        end
    end

    // Timer and error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                trcd_q[b] <= 4'd0;
                trp_q[b]  <= 4'd0;
            end
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            trcd_q     <= trcd_d;
            trp_q      <= trp_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    localparam int unused_timing_p = TRCD + TRP;
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_resp.sv
// Directed self-checking bench for sdram_resp: write/read bursts, wrap, byte mask, interruption, reset, errors.
module tb_sdram_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        mode_ok;
    logic        err;
    logic [2:0]  err_code;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_BSTOP = 4'b0110;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_AREF  = 4'b0001;
    localparam logic [3:0] C_LMR   = 4'b0000;

`ifdef SDRAM_RESP_CHECK_EN
    localparam logic       EXP_ERR  = 1'b1;
    localparam logic [2:0] EXP_TRCD = 3'd3;
    localparam logic [2:0] EXP_REF  = 3'd5;
`else
    localparam logic       EXP_ERR  = 1'b0;
    localparam logic [2:0] EXP_TRCD = 3'd0;
    localparam logic [2:0] EXP_REF  = 3'd0;
`endif

    sdram_resp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdram_cke  (cke),
        .sdram_cs_n (cs_n),
        .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n),
        .sdram_we_n (we_n),
        .sdram_ba   (ba),
        .sdram_addr (addr),
        .sdram_dqm  (dqm),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .mode_ok    (mode_ok),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present one command for one cycle, then sample just after the edge.
    task automatic drv(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba    = b;
        addr  = a;
        dqm   = m;
        dq_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drv(C_NOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        nop();
        nop();
        nop();
        chkb("rst_dq_oe", dq_oe, 1'b0);
        chk("rst_dq_out", dq_out, 16'h0000);
        chkb("rst_mode_ok", mode_ok, 1'b0);
        chkb("rst_err", err, 1'b0);
        chk("rst_err_code", {13'd0, err_code}, 16'h0000);
        rst_n = 1'b1;

        // READ before any LMR is ignored
        drv(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0000);
        nop();
        nop();
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chkb("pre_lmr_no_oe", dq_oe, 1'b0);
            nop();
        end

        // CL3, page burst: write 1..8 then BSTOP
        drv(C_LMR, 2'd0, 13'h0037, 2'b00, 16'h0000);
        chkb("mode_ok_set", mode_ok, 1'b1);
        drv(C_WRITE, 2'd0, 13'h0000, 2'b00, 16'h0001);
        for (int i = 2; i <= 8; i++) drv(C_NOP, 2'd0, 13'h0000, 2'b00, 16'(i));
        drv(C_BSTOP, 2'd0, 13'h0000, 2'b00, 16'h0000);

        // CL3, BL8 read back with latency 3
        drv(C_LMR, 2'd0, 13'h0033, 2'b00, 16'h0000);
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        chkb("cl3_oe_t1", dq_oe, 1'b0);
        nop();
        chkb("cl3_oe_t2", dq_oe, 1'b0);
        nop();
        chkb("cl3_oe_t3", dq_oe, 1'b1);
        chk("bl8_beat1", dq_out, 16'h0001);
        for (int i = 2; i <= 8; i++) begin
            nop();
            chkb("bl8_oe", dq_oe, 1'b1);
            chk("bl8_beat", dq_out, 16'(i));
        end
        nop();
        chkb("bl8_end_oe", dq_oe, 1'b0);

        // CL2, BL4: column wrap within the page
        drv(C_LMR, 2'd0, 13'h0022, 2'b00, 16'h0000);
        drv(C_WRITE, 2'd0, 13'h01FE, 2'b00, 16'h000A);
        drv(C_NOP, 2'd0, 13'h0000, 2'b00, 16'h000B);
        drv(C_NOP, 2'd0, 13'h0000, 2'b00, 16'h000C);
        drv(C_NOP, 2'd0, 13'h0000, 2'b00, 16'h000D);
        nop();
        drv(C_READ, 2'd0, 13'h01FE, 2'b00, 16'h0000);
        chkb("cl2_oe_t1", dq_oe, 1'b0);
        nop();
        chk("wrap_1fe", dq_out, 16'h000A);
        nop();
        chk("wrap_1ff", dq_out, 16'h000B);
        nop();
        chk("wrap_000", dq_out, 16'h000C);
        nop();
        chk("wrap_001", dq_out, 16'h000D);
        nop();
        chkb("bl4_end_oe", dq_oe, 1'b0);
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        nop();
        chk("col0_over", dq_out, 16'h000C);
        nop();
        chk("col1_over", dq_out, 16'h000D);
        nop();
        chk("col2_kept", dq_out, 16'h0003);
        nop();
        chk("col3_kept", dq_out, 16'h0004);
        nop();

        // Single-beat writes with low-byte mask, read the next cycle
        drv(C_LMR, 2'd0, 13'h0222, 2'b00, 16'h0000);
        drv(C_WRITE, 2'd0, 13'h0010, 2'b00, 16'hABCD);
        drv(C_WRITE, 2'd0, 13'h0010, 2'b01, 16'h1234);
        drv(C_READ, 2'd0, 13'h0010, 2'b00, 16'h0000);
        nop();
        chkb("mask_oe", dq_oe, 1'b1);
        chk("mask_data", dq_out, 16'h12CD);
        for (int i = 0; i < 4; i++) nop();
        chkb("mask_drain_oe", dq_oe, 1'b0);

        // Page read interrupted by WRITE two beats in
        drv(C_LMR, 2'd0, 13'h0027, 2'b00, 16'h0000);
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        nop();
        chkb("intr_first_oe", dq_oe, 1'b1);
        chk("intr_first_data", dq_out, 16'h000C);
        drv(C_WRITE, 2'd0, 13'h0020, 2'b00, 16'h5555);
        chkb("intr_drop_oe", dq_oe, 1'b0);
        drv(C_BSTOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
        chkb("intr_after_oe", dq_oe, 1'b0);
        nop();
        chkb("intr_quiet_oe", dq_oe, 1'b0);
        drv(C_READ, 2'd0, 13'h0020, 2'b00, 16'h0000);
        drv(C_BSTOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
        chk("intr_written", dq_out, 16'h5555);
        nop();
        chkb("bstop_oe", dq_oe, 1'b0);
        chkb("no_err_yet", err, 1'b0);

        // READ one cycle after ACT, then ACT to an already open bank
        drv(C_ACT, 2'd1, 13'h0002, 2'b00, 16'h0000);
        drv(C_READ, 2'd1, 13'h0000, 2'b00, 16'h0000);
        chkb("trcd_err", err, EXP_ERR);
        chk("trcd_code", {13'd0, err_code}, {13'd0, EXP_TRCD});
        drv(C_BSTOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
        drv(C_ACT, 2'd0, 13'h0005, 2'b00, 16'h0000);
        nop();
        chk("sticky_code", {13'd0, err_code}, {13'd0, EXP_TRCD});
        nop();

        // Reset in the middle of a read burst
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        nop();
        chk("prereset_data", dq_out, 16'h000C);
        rst_n = 1'b0;
        nop();
        chkb("midrst_oe", dq_oe, 1'b0);
        chkb("midrst_mode_ok", mode_ok, 1'b0);
        chkb("midrst_err", err, 1'b0);
        chk("midrst_code", {13'd0, err_code}, 16'h0000);
        rst_n = 1'b1;
        nop();

        // AREF with a bank open; storage survives reset
        drv(C_LMR, 2'd0, 13'h0027, 2'b00, 16'h0000);
        drv(C_ACT, 2'd0, 13'h0001, 2'b00, 16'h0000);
        nop();
        drv(C_AREF, 2'd0, 13'h0000, 2'b00, 16'h0000);
        chkb("aref_err", err, EXP_ERR);
        chk("aref_code", {13'd0, err_code}, {13'd0, EXP_REF});
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        drv(C_BSTOP, 2'd0, 13'h0000, 2'b00, 16'h0000);
        chkb("persist_oe", dq_oe, 1'b1);
        chk("persist_data", dq_out, 16'h000C);
        nop();
        chkb("persist_end_oe", dq_oe, 1'b0);

        // PRE-all closes the bank, so a READ is ignored
        drv(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
        drv(C_READ, 2'd0, 13'h0000, 2'b00, 16'h0000);
        nop();
        chkb("pre_all_no_oe", dq_oe, 1'b0);
        nop();
        chkb("pre_all_no_oe2", dq_oe, 1'b0);
        chk("pre_all_code", {13'd0, err_code}, {13'd0, EXP_REF});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
